// File: rtl/nmcu_pkg.sv
// Shared NMCU definitions for the PE result writeback path.
//   DATA_WIDTH / PSUM_WIDTH / SHIFT_WIDTH : element, partial-sum and shift widths
//   ARRAY_DIM / WB_ROW_IDX_W              : PE array dimension and row index width
//   wb_state_t                            : writeback FSM states
//   requant_sat()                         : rounding arithmetic shift + signed saturation
package nmcu_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int PSUM_WIDTH   = 32;
  localparam int SHIFT_WIDTH  = 5;
  localparam int ARRAY_DIM    = 4;
  localparam int WB_ROW_IDX_W = $clog2(ARRAY_DIM);

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_SEND = 1'b1
  } wb_state_t;

  // Saturation bounds, held one bit wider than a PSUM so the rounded value
  // can be compared without wrapping.
  localparam logic signed [PSUM_WIDTH:0] SAT_MAX = (PSUM_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [PSUM_WIDTH:0] SAT_MIN = (PSUM_WIDTH+1)'(-(2**(DATA_WIDTH-1)));

  // Round-half-up arithmetic right shift, then clamp to the signed DATA_WIDTH
  // range. The extra bit keeps psum + rounding constant from overflowing.
  function automatic logic [DATA_WIDTH-1:0] requant_sat(
    input logic [PSUM_WIDTH-1:0]  psum,
    input logic [SHIFT_WIDTH-1:0] shift
  );
    logic signed [PSUM_WIDTH:0] ext;
    logic signed [PSUM_WIDTH:0] half;
    logic signed [PSUM_WIDTH:0] shifted;
    logic [DATA_WIDTH-1:0]      result;
    ext  = signed'({psum[PSUM_WIDTH-1], psum});
    half = '0;
    if (shift != '0) begin
      half[shift - SHIFT_WIDTH'(1)] = 1'b1;
      shifted = (ext + half) >>> shift;
    end else begin
      shifted = ext;
    end
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/pe_requant_lane.sv
// One combinational requantization lane: PSUM -> DATA_WIDTH element.
// Build option: define NMCU_WB_RELU_EN to clamp negative PSUMs to zero
// before rounding (fused ReLU); otherwise full signed requantization.
//   psum  : signed partial sum
//   shift : requant right-shift amount
//   data  : saturated element
module pe_requant_lane
  import nmcu_pkg::*;
(
  input  logic [PSUM_WIDTH-1:0]  psum,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [DATA_WIDTH-1:0]  data
);

  logic [PSUM_WIDTH-1:0] lane_psum;

`ifdef NMCU_WB_RELU_EN
  assign lane_psum = psum[PSUM_WIDTH-1] ? '0 : psum;
`else
  assign lane_psum = psum;
`endif

  assign data = requant_sat(lane_psum, shift);

endmodule

// File: rtl/pe_result_writeback.sv
// PE result writeback: captures the PSUM matrix on a rising pe_done_i,
// requantizes it row by row and streams one row per valid/ready beat.
// Build option: NMCU_WB_RELU_EN (see pe_requant_lane).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pe_done_i           : PE result valid level; rising edge captures
//   pe_result_i         : [row][col] signed PSUM matrix
//   cfg_base_addr_i     : destination base row address, latched at capture
//   cfg_shift_i         : requant shift, latched at capture
//   wb_valid_o/ready_i  : row beat handshake
//   wb_addr_o           : base + row index (wraps)
//   wb_data_o           : requantized row, col 0 in LSBs
//   wb_last_o           : final row of the matrix
//   busy_o              : drain in flight
//   overflow_o          : sticky, a capture was dropped; clr_overflow_i clears
// The lane datapath is sized by nmcu_pkg; DATA_WIDTH, PSUM_WIDTH and
// SHIFT_WIDTH must keep their package defaults.
module pe_result_writeback #(
  parameter int DATA_WIDTH  = nmcu_pkg::DATA_WIDTH,
  parameter int PSUM_WIDTH  = nmcu_pkg::PSUM_WIDTH,
  parameter int ARRAY_DIM   = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              pe_done_i,
  input  logic [ARRAY_DIM-1:0][ARRAY_DIM-1:0][PSUM_WIDTH-1:0] pe_result_i,
  input  logic [ADDR_WIDTH-1:0]                             cfg_base_addr_i,
  input  logic [SHIFT_WIDTH-1:0]                            cfg_shift_i,
  output logic                                              wb_valid_o,
  input  logic                                              wb_ready_i,
  output logic [ADDR_WIDTH-1:0]                             wb_addr_o,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0]                   wb_data_o,
  output logic                                              wb_last_o,
  output logic                                              busy_o,
  output logic                                              overflow_o,
  input  logic                                              clr_overflow_i
);

  import nmcu_pkg::*;

  localparam int ROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_DIM - 1);

  wb_state_t state_q, state_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic done_q;
  logic overflow_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [ARRAY_DIM-1:0][ARRAY_DIM-1:0][PSUM_WIDTH-1:0] psum_buf_q;

  logic capture, send, last_row, transfer, load, drop;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] row_data;

  assign capture  = pe_done_i & ~done_q;
  assign send     = (state_q == WB_SEND);
  assign last_row = (row_idx_q == ROW_LAST);
  assign transfer = send & wb_ready_i;
  // A capture is taken when idle, or when it lands on the final-row
  // transfer so back-to-back matrices drain with no bubble.
  assign load     = capture & (~send | (transfer & last_row));
  assign drop     = capture & ~load;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    case (state_q)
      WB_IDLE: begin
        if (capture) begin
          state_d   = WB_SEND;
          row_idx_d = '0;
        end
      end
      WB_SEND: begin
        if (transfer) begin
          if (last_row) begin
            row_idx_d = '0;
            state_d   = capture ? WB_SEND : WB_IDLE;
          end else begin
            row_idx_d = row_idx_q + ROW_W'(1);
          end
        end
      end
      default: begin
        state_d   = WB_IDLE;
        row_idx_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WB_IDLE;
      row_idx_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      base_q     <= '0;
      shift_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      done_q    <= pe_done_i;
      if (load) begin
        base_q  <= cfg_base_addr_i;
        shift_q <= cfg_shift_i;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // NOTE: the PSUM buffer has no reset; its contents are never visible
  // outside SEND, and SEND is only reached through a fresh load.
  always_ff @(posedge clk) begin
    if (load) begin
      psum_buf_q <= pe_result_i;
    end
  end

  for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_lane
    pe_requant_lane u_lane (
      .psum  (psum_buf_q[row_idx_q][c]),
      .shift (shift_q),
      .data  (row_data[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Outputs are gated by SEND so they read zero out of reset and when idle.
  assign wb_valid_o = send;
  assign busy_o     = send;
  assign wb_last_o  = send & last_row;
  assign wb_addr_o  = send ? (base_q + ADDR_WIDTH'(row_idx_q)) : '0;
  assign wb_data_o  = send ? row_data : '0;
  assign overflow_o = overflow_q;

endmodule
